// File: rtl/rr_arbiter16_pkg.sv
// Shared definitions for the 16-way round-robin arbiter.
// Holds the FSM state encoding, the requester count/index width and the
// default maximum grant length used by rr_arbiter16.
package rr_arbiter16_pkg;

  localparam int N_REQ            = 16;
  localparam int IDX_W            = 4;
  localparam int HOLD_MAX_DEFAULT = 15;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

endpackage

// File: rtl/rr_arbiter16_dec4to16.sv
// 4-to-16 one-hot decoder with enable.
// Ports:
//   idx    - binary index to decode
//   en     - when low the output is all-zero
//   onehot - one-hot decode of idx, gated by en
module dec4to16
  import rr_arbiter16_pkg::*;
(
  input  logic [IDX_W-1:0] idx,
  input  logic             en,
  output logic [N_REQ-1:0] onehot
);

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_bit
      assign onehot[gi] = en && (idx == IDX_W'(gi));
    end
  endgenerate

endmodule

// File: rtl/rr_arbiter16.sv
// 16-requester round-robin arbiter with bounded grant length.
// An IDLE cycle arbitrates among the requests (circular scan from ptr),
// the winner holds the grant until it pulses done, drops its request, or
// has held it for HOLD_MAX cycles (forced release, flagged by timeout).
// Ports:
//   clk       - clock, rising edge
//   rst_n     - asynchronous active-low reset
//   req       - request vector, bit i = requester i
//   done      - release pulse from the current grantee
//   gnt       - one-hot grant vector (zero when no grant)
//   gnt_idx   - binary index of the grantee (zero when no grant)
//   gnt_valid - high while a grant is held
//   timeout   - one-cycle pulse after a forced release
module rr_arbiter16
  import rr_arbiter16_pkg::*;
#(
  parameter int HOLD_MAX = HOLD_MAX_DEFAULT,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic             done,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_valid,
  output logic             timeout
);

  state_t             state_reg, state_next;
  logic [IDX_W-1:0]   ptr_reg, ptr_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic [IDX_W-1:0]   idx_reg, idx_next;
  logic               timeout_reg, timeout_next;

  logic [IDX_W-1:0]   pick_idx;
  logic [IDX_W-1:0]   cand;
  logic               hold_expired;
  logic               grant_release;

  // Circular priority search: scan offsets from highest to lowest so the
  // requester closest to ptr (smallest offset) is the last writer and wins.
  always_comb begin
    pick_idx = '0;
    cand     = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      cand = ptr_reg + IDX_W'(k);
      if (req[cand]) begin
        pick_idx = cand;
      end
    end
  end

  assign hold_expired  = (cnt_reg == CNT_W'(HOLD_MAX - 1));
  assign grant_release = done || !req[idx_reg] || hold_expired;

  always_comb begin
    state_next   = state_reg;
    ptr_next     = ptr_reg;
    cnt_next     = cnt_reg;
    idx_next     = idx_reg;
    timeout_next = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (req != '0) begin
          idx_next   = pick_idx;
          cnt_next   = '0;
          state_next = ST_GRANT;
        end
      end
      ST_GRANT: begin
        if (grant_release) begin
          state_next   = ST_IDLE;
          idx_next     = '0;
          cnt_next     = '0;
          ptr_next     = idx_reg + IDX_W'(1);
          // Only a pure hold-limit release counts as a timeout.
          timeout_next = hold_expired && !done && req[idx_reg];
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= ST_IDLE;
      ptr_reg     <= '0;
      cnt_reg     <= '0;
      idx_reg     <= '0;
      timeout_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      ptr_reg     <= ptr_next;
      cnt_reg     <= cnt_next;
      idx_reg     <= idx_next;
      timeout_reg <= timeout_next;
    end
  end

  assign gnt_valid = (state_reg == ST_GRANT);
  assign gnt_idx   = idx_reg;
  assign timeout   = timeout_reg;

  dec4to16 u_dec (
    .idx    (idx_reg),
    .en     (gnt_valid),
    .onehot (gnt)
  );

endmodule
